// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin read scheduler that drains up to LANES
// data/index FIFOs into a single valid/ready consumer, one read in flight.
// Optional burst mode (consecutive reads from one lane, up to BURST_LEN)
// is enabled by defining the macro ARB_BURST_EN.
module fifo_read_arbiter #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned D_WIDTH   = 16,
    parameter int unsigned I_WIDTH   = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             fifo_empty,
    input  logic [LANES*D_WIDTH-1:0]     fifo_data,
    input  logic [LANES*I_WIDTH-1:0]     fifo_index,
    input  logic [LANES-1:0]             lane_mask,
    output logic [LANES-1:0]             fifo_r_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [D_WIDTH-1:0]           out_data,
    output logic [I_WIDTH-1:0]           out_index,
    output logic [$clog2(LANES)-1:0]     out_lane,
    output logic                         busy
);

    localparam int unsigned LW = $clog2(LANES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Reject parameter sets the lane encoding and burst counter cannot support
    if (LANES < 2 || LANES > 8 || BURST_LEN < 1) begin : g_param_check
        $error("fifo_read_arbiter: unsupported LANES/BURST_LEN");
    end

    logic [1:0]         state_q, state_d;
    logic [LW-1:0]      grant_q, grant_d;
    logic [LW-1:0]      last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [D_WIDTH-1:0] out_data_q, out_data_d;
    logic [I_WIDTH-1:0] out_index_q, out_index_d;
    logic [LW-1:0]      out_lane_q, out_lane_d;

`ifdef ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    logic [LANES-1:0]   req;
    logic [LW-1:0]      pick;
    logic               pick_vld;
    logic               take_pick;
    logic [D_WIDTH-1:0] sel_data;
    logic [I_WIDTH-1:0] sel_index;

    // Lane index "off" positions after base, wrapping at LANES
    function automatic logic [LW-1:0] rr_idx(input logic [LW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= LANES) s = s - LANES;
        return LW'(s);
    endfunction

    assign req = ~fifo_empty & lane_mask;

    // Round-robin pick: first requesting lane after the last granted one
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= LANES; i++) begin
            if (!pick_vld && req[rr_idx(last_q, i)]) begin
                pick     = rr_idx(last_q, i);
                pick_vld = 1'b1;
            end
        end
    end

    // Select the granted lane's registered FIFO output
    always_comb begin
        sel_data  = '0;
        sel_index = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (grant_q == LW'(k)) begin
                sel_data  = fifo_data[k*D_WIDTH +: D_WIDTH];
                sel_index = fifo_index[k*I_WIDTH +: I_WIDTH];
            end
        end
    end

    // One-cycle read strobe to the granted FIFO, suppressed during reset
    always_comb begin
        fifo_r_en = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (!rst && state_q == ST_READ && grant_q == LW'(k)) fifo_r_en[k] = 1'b1;
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_lane_d  = out_lane_q;
        take_pick   = 1'b0;
`ifdef ARB_BURST_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: take_pick = 1'b1;
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                out_data_d  = sel_data;
                out_index_d = sel_index;
                out_lane_d  = grant_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef ARB_BURST_EN
                    if (cnt_q < CNT_W'(BURST_LEN - 1) && req[grant_q]) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_READ;
                    end else begin
                        take_pick = 1'b1;
                    end
`else
                    take_pick = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_pick) begin
`ifdef ARB_BURST_EN
            cnt_d = '0;
`endif
            if (pick_vld) begin
                grant_d = pick;
                last_d  = pick;
                state_d = ST_READ;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= LW'(LANES - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_lane_q  <= '0;
`ifdef ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_lane_q  <= out_lane_d;
`ifdef ARB_BURST_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_lane  = out_lane_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with behavioural per-lane FIFOs.
module tb_fifo_read_arbiter;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 4;
    localparam int unsigned DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      fifo_empty;
    logic [LANES*DW-1:0]   fifo_data;
    logic [LANES*IW-1:0]   fifo_index;
    logic [LANES-1:0]      lane_mask;
    logic [LANES-1:0]      fifo_r_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [IW-1:0]         out_index;
    logic [1:0]            out_lane;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural FIFOs: registered data_out, empty from pointers
    logic [DW-1:0] mem_d [LANES][DEPTH];
    logic [IW-1:0] mem_i [LANES][DEPTH];
    int unsigned   wp [LANES] = '{default: 0};
    int unsigned   rp [LANES] = '{default: 0};
    logic [DW-1:0] dout [LANES] = '{default: '0};
    logic [IW-1:0] iout [LANES] = '{default: '0};
    int            pops      = 0;
    int            underflow = 0;
    int            rst_rd    = 0;
    int            multi_rd  = 0;
    int            nxt [LANES];

    fifo_read_arbiter #(.LANES(LANES), .D_WIDTH(DW), .I_WIDTH(IW), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_index (fifo_index),
        .lane_mask  (lane_mask),
        .fifo_r_en  (fifo_r_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_lane   (out_lane),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            fifo_data[k*DW +: DW]  = dout[k];
            fifo_index[k*IW +: IW] = iout[k];
            fifo_empty[k]          = (rp[k] == wp[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (rst) begin
                rp[k] <= wp[k];
            end else if (fifo_r_en[k]) begin
                if (rp[k] == wp[k]) begin
                    underflow <= underflow + 1;
                end else begin
                    dout[k] <= mem_d[k][rp[k] % DEPTH];
                    iout[k] <= mem_i[k][rp[k] % DEPTH];
                    rp[k]   <= rp[k] + 1;
                end
            end
        end
        if (!rst && fifo_r_en != '0) pops <= pops + 1;
        if (rst && fifo_r_en != '0) rst_rd <= rst_rd + 1;
        if ($countones(fifo_r_en) > 1) multi_rd <= multi_rd + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input logic [DW-1:0] d, input logic [IW-1:0] i);
        mem_d[lane][wp[lane] % DEPTH] = d;
        mem_i[lane][wp[lane] % DEPTH] = i;
        wp[lane] = wp[lane] + 1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) nxt[k] = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic expect_word(input string tag, input logic [DW-1:0] d,
                               input logic [IW-1:0] i, input logic [1:0] l);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"},  32'(out_data),  32'(d));
        check_eq({tag, "_index"}, 32'(out_index), 32'(i));
        check_eq({tag, "_lane"},  32'(out_lane),  32'(l));
    endtask

    // Wait for a word from the expected lane, check it, then let it handshake
    task automatic take_lane(input string tag, input int lane);
        wait_valid(tag);
        expect_word(tag, 16'(16'h0100 * lane + nxt[lane]), 4'(nxt[lane]), 2'(lane));
        nxt[lane]++;
        tick();
    endtask

    int exp_fair [6];
    int exp_burst [8];
    int p;

    initial begin
`ifdef ARB_BURST_EN
        exp_fair  = '{0, 0, 1, 1, 3, 3};
        exp_burst = '{0, 0, 0, 0, 1, 1, 0, 0};
`else
        exp_fair  = '{0, 1, 3, 0, 1, 3};
        exp_burst = '{0, 1, 0, 1, 0, 0, 0, 0};
`endif
        out_ready = 1'b1;
        lane_mask = 4'hF;
        do_reset(3);

        // Reset values
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_ren",   32'(fifo_r_en), 32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_index", 32'(out_index), 32'd0);
        check_eq("rst_lane",  32'(out_lane),  32'd0);

        // Non-empty but masked lane must not be granted
        lane_mask = 4'h0;
        push(0, 16'h0EEE, 4'd7);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("masked_busy", 32'(busy),      32'd0);
            check_eq("masked_ren",  32'(fifo_r_en), 32'd0);
        end
        lane_mask = 4'hF;
        do_reset(2);

        // Single lane: exact latency and ordering
        push(2, 16'h00A1, 4'd1);
        push(2, 16'h00A2, 4'd2);
        push(2, 16'h00A3, 4'd3);
        tick();
        check_eq("lat_read_ren",  32'(fifo_r_en), 32'b0100);
        check_eq("lat_read_busy", 32'(busy),      32'd1);
        tick();
        check_eq("lat_capt_valid", 32'(out_valid), 32'd0);
        check_eq("lat_capt_ren",   32'(fifo_r_en), 32'd0);
        tick();
        expect_word("w1", 16'h00A1, 4'd1, 2'd2);
        tick();
        check_eq("w1_hs_valid", 32'(out_valid), 32'd0);
        check_eq("w2_read_ren", 32'(fifo_r_en), 32'b0100);
        tick();
        tick();
        expect_word("w2", 16'h00A2, 4'd2, 2'd2);
        repeat (3) tick();
        expect_word("w3", 16'h00A3, 4'd3, 2'd2);
        tick();
        check_eq("drain_busy",  32'(busy),      32'd0);
        check_eq("drain_ren",   32'(fifo_r_en), 32'd0);
        check_eq("drain_valid", 32'(out_valid), 32'd0);
        check_eq("drain_keep",  32'(out_data),  32'h00A1 + 32'd2);
        tick();
        check_eq("drain_idle_ren", 32'(fifo_r_en), 32'd0);

        // Fairness across lanes 0,1,3
        do_reset(2);
        for (int w = 0; w < 2; w++) begin
            push(0, 16'(16'h0000 + w), 4'(w));
            push(1, 16'(16'h0100 + w), 4'(w));
            push(3, 16'(16'h0300 + w), 4'(w));
        end
        for (int n = 0; n < 6; n++) take_lane("fair", exp_fair[n]);

        // Burst behaviour: lane 0 six words, lane 1 two words
        do_reset(2);
        for (int w = 0; w < 6; w++) push(0, 16'(w), 4'(w));
        for (int w = 0; w < 2; w++) push(1, 16'(16'h0100 + w), 4'(w));
        for (int n = 0; n < 8; n++) take_lane("burst", exp_burst[n]);

        // Backpressure in HOLD
        do_reset(2);
        out_ready = 1'b0;
        push(1, 16'h0100, 4'd0);
        push(1, 16'h0101, 4'd1);
        wait_valid("bp");
        expect_word("bp_first", 16'h0100, 4'd0, 2'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_data",  32'(out_data),  32'h0100);
            check_eq("bp_lane",  32'(out_lane),  32'd1);
            check_eq("bp_ren",   32'(fifo_r_en), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_next_ren",   32'(fifo_r_en), 32'b0010);
        check_eq("bp_next_valid", 32'(out_valid), 32'd0);
        nxt[1] = 1;
        take_lane("bp_second", 1);

        // Mask: lane 1 excluded, then unmasked mid-HOLD
        do_reset(2);
        lane_mask = 4'b1101;
        for (int k = 0; k < LANES; k++) push(k, 16'(16'h0100 * k), 4'd0);
        push(3, 16'h0301, 4'd1);
        take_lane("mask", 0);
        take_lane("mask", 2);
        take_lane("mask", 3);
        wait_valid("mask4");
        lane_mask = 4'hF;
        take_lane("mask4", 3);
        take_lane("unmask", 1);
        tick();
        check_eq("mask_end_busy", 32'(busy), 32'd0);

        // Reset during HOLD with work still queued
        do_reset(2);
        out_ready = 1'b0;
        push(0, 16'h0D01, 4'd5);
        push(2, 16'h0D02, 4'd6);
        wait_valid("rhold");
        p = pops;
        rst = 1'b1;
        #1;
        check_eq("rhold_ren_now", 32'(fifo_r_en), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rhold_valid", 32'(out_valid), 32'd0);
            check_eq("rhold_busy",  32'(busy),      32'd0);
            check_eq("rhold_ren",   32'(fifo_r_en), 32'd0);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        check_eq("rhold_pops", 32'(pops), 32'(p));
        tick();
        check_eq("rhold_after_busy", 32'(busy), 32'd0);

        // Reset asserted during READ suppresses the read strobe
        push(1, 16'h0E01, 4'd2);
        tick();
        check_eq("rread_ren_pre", 32'(fifo_r_en), 32'b0010);
        p = pops;
        rst = 1'b1;
        #1;
        check_eq("rread_ren", 32'(fifo_r_en), 32'd0);
        tick();
        rst = 1'b0;
        check_eq("rread_busy", 32'(busy), 32'd0);
        check_eq("rread_pops", 32'(pops), 32'(p));
        tick();

        // Global FIFO protocol monitors
        check_eq("underflow", 32'(underflow), 32'd0);
        check_eq("rst_reads", 32'(rst_rd),    32'd0);
        check_eq("multi_ren", 32'(multi_rd),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
